// File: rtl/mem_port_arbiter.sv
// Two-master / one-slave arbiter that shares one req/ready memory port between the
// instruction-fetch and data ports. It has a bus-timeout watchdog. Optional macro: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_PRIO      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_req,
  output logic        o_if_ready,
  output logic [31:0] o_if_rdata,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic        i_d_we,
  input  logic [2:0]  i_d_mode,
  input  logic        i_d_req,
  output logic        o_d_ready,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic [2:0]  o_mem_mode,
  output logic        o_mem_req,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        state_reg;
  state_t        next_grant;
  logic [CW-1:0] wd_cnt_reg;
  logic          bus_err_reg;
  logic          granted;
  logic          timeout_hit;
  logic          done;
  logic          tie_to_d;

  assign granted = (state_reg != IDLE);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
      // A ready in the last allowed cycle takes precedence over the abort.
      assign timeout_hit = granted && !i_mem_ready && (wd_cnt_reg == WD_LAST);
    end else begin : g_no_wd
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign done = granted && (i_mem_ready || timeout_hit);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_reg;
  assign tie_to_d = !last_d_reg;
`else
  assign tie_to_d = (DATA_PRIO != 0);
`endif

  always_comb begin
    next_grant = IDLE;
    if (i_if_req && i_d_req) begin
      next_grant = tie_to_d ? GNT_D : GNT_IF;
    end else if (i_d_req) begin
      next_grant = GNT_D;
    end else if (i_if_req) begin
      next_grant = GNT_IF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      wd_cnt_reg  <= '0;
      bus_err_reg <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_reg  <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg  <= next_grant;
          wd_cnt_reg <= '0;
`ifdef ARB_ROUND_ROBIN_EN
          if (next_grant != IDLE) begin
            last_d_reg <= (next_grant == GNT_D);
          end
`endif
        end
        GNT_IF, GNT_D: begin
          if (done) begin
            state_reg  <= IDLE;
            wd_cnt_reg <= '0;
            if (timeout_hit) begin
              bus_err_reg <= 1'b1;
            end
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The memory bus is steered purely from the state, so an async reset drops it at once.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    o_mem_mode  = '0;
    o_if_ready  = 1'b0;
    o_if_rdata  = '0;
    o_d_ready   = 1'b0;
    o_d_rdata   = '0;
    case (state_reg)
      GNT_IF: begin
        o_mem_req  = 1'b1;
        o_mem_addr = i_if_addr;
        o_mem_mode = 3'b010;
        o_if_ready = done;
        o_if_rdata = i_mem_ready ? i_mem_rdata : '0;
      end
      GNT_D: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = i_d_addr;
        o_mem_wdata = i_d_wdata;
        o_mem_we    = i_d_we;
        o_mem_mode  = i_d_mode;
        o_d_ready   = done;
        o_d_rdata   = i_mem_ready ? i_mem_rdata : '0;
      end
      default: ;
    endcase
  end

  assign o_bus_err = bus_err_reg;

endmodule
